// File: rtl/fir_pkg.sv
// Shared elaboration helpers for the pipelined FIR: bit-width, latency and
// adder-tree sizing functions.
package fir_pkg;

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((64'd1 << r) < 64'(v)) r++;
    return r;
  endfunction

  // Sample strobe to output strobe, in clock edges.
  function automatic int unsigned latency(input int unsigned n);
    return 3 + clog2(n);
  endfunction

  function automatic int unsigned guard_bits(input int unsigned n);
    return clog2(n);
  endfunction

  // Number of live nodes at a given level of a pairwise reduction tree.
  function automatic int unsigned level_count(input int unsigned n, input int unsigned lvl);
    return (n + (32'd1 << lvl) - 1) >> lvl;
  endfunction

endpackage

// File: rtl/fir_adder_tree.sv
// Registered pairwise adder tree with a valid bit travelling alongside the data.
// One register level per halving; odd leftovers pass straight through a level.
module fir_adder_tree
  import fir_pkg::*;
#(
  parameter int unsigned N = 5,
  parameter int unsigned W = 36
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    clr_i,
  input  logic                    valid_i,
  input  logic [N*W-1:0]          data_i,
  output logic [W+clog2(N)-1:0]   sum_o,
  output logic                    valid_o
);

  localparam int unsigned Levels = clog2(N);
  localparam int unsigned SW     = W + Levels;

  for (genvar l = 0; l <= Levels; l++) begin : g_lvl
    localparam int unsigned Cnt = level_count(N, l);
    logic [SW-1:0] node [Cnt];
    logic          vld;

    if (l == 0) begin : g_in
      for (genvar i = 0; i < Cnt; i++) begin : g_ext
        assign node[i] = SW'($signed(data_i[i*W +: W]));
      end
      assign vld = valid_i;
    end else begin : g_add
      localparam int unsigned PrevCnt = level_count(N, l - 1);
      logic [SW-1:0] node_d [Cnt];
      logic [SW-1:0] node_q [Cnt];
      logic          vld_d;
      logic          vld_q;

      for (genvar i = 0; i < Cnt; i++) begin : g_node
        if (2 * i + 1 < PrevCnt) begin : g_pair
          assign node_d[i] = g_lvl[l-1].node[2*i] + g_lvl[l-1].node[2*i+1];
        end else begin : g_pass
          assign node_d[i] = g_lvl[l-1].node[2*i];
        end
      end

      assign vld_d = g_lvl[l-1].vld & ~clr_i;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          for (int unsigned i = 0; i < Cnt; i++) node_q[i] <= '0;
          vld_q <= 1'b0;
        end else begin
          node_q <= node_d;
          vld_q  <= vld_d;
        end
      end

      assign node = node_q;
      assign vld  = vld_q;
    end
  end

  assign sum_o   = g_lvl[Levels].node[0];
  assign valid_o = g_lvl[Levels].vld;

endmodule

// File: rtl/fir_1d_n_logic.sv
// Strobed direct-form FIR: delay line, registered products, registered adder tree,
// round stage, saturate stage. Double-banked coefficients swapped atomically.
module fir_1d_n_logic
  import fir_pkg::*;
#(
  parameter int unsigned NUM_TAPS   = 5,
  parameter int unsigned IN_WIDTH   = 18,
  parameter int unsigned COEF_WIDTH = 18,
  parameter int unsigned OUT_WIDTH  = 48,
  parameter int unsigned SHIFT      = 0
) (
  input  logic                         CLK,
  input  logic                         RST_N,
  input  logic [IN_WIDTH-1:0]          X,
  input  logic                         X_STRB,
  input  logic                         FLUSH,
  input  logic                         COEF_WE,
  input  logic [clog2(NUM_TAPS)-1:0]   COEF_ADDR,
  input  logic [COEF_WIDTH-1:0]        COEF_DATA,
  input  logic                         COEF_SWAP,
  output logic [OUT_WIDTH-1:0]         Y,
  output logic                         Y_STRB,
  output logic                         Y_SAT
);

  localparam int unsigned PW = IN_WIDTH + COEF_WIDTH;
  localparam int unsigned SW = PW + guard_bits(NUM_TAPS);
  localparam int unsigned RW = SW + 1;
  localparam logic signed [RW-1:0] RndBias = (RW'(1) << SHIFT) >> 1;

  logic signed [IN_WIDTH-1:0]   taps_d   [NUM_TAPS];
  logic signed [IN_WIDTH-1:0]   taps_q   [NUM_TAPS];
  logic signed [COEF_WIDTH-1:0] shadow_d [NUM_TAPS];
  logic signed [COEF_WIDTH-1:0] shadow_q [NUM_TAPS];
  logic signed [COEF_WIDTH-1:0] active_d [NUM_TAPS];
  logic signed [COEF_WIDTH-1:0] active_q [NUM_TAPS];
  logic signed [PW-1:0]         prod_d   [NUM_TAPS];
  logic signed [PW-1:0]         prod_q   [NUM_TAPS];
  logic [NUM_TAPS*PW-1:0]       prod_flat;
  logic                         vld1_d, vld1_q, vld2_d, vld2_q, vld3_d, vld3_q;
  logic [SW-1:0]                tree_sum;
  logic                         tree_vld;
  logic signed [RW-1:0]         biased;
  logic signed [RW-1:0]         rnd_d, rnd_q;
  logic signed [OUT_WIDTH-1:0]  clip;
  logic                         clip_hit;
  logic signed [OUT_WIDTH-1:0]  y_d, y_q;
  logic                         y_strb_d, y_strb_q, y_sat_d, y_sat_q;

  always_comb begin
    taps_d = taps_q;
    vld1_d = X_STRB & ~FLUSH;
    if (FLUSH) begin
      for (int unsigned k = 0; k < NUM_TAPS; k++) taps_d[k] = '0;
    end else if (X_STRB) begin
      taps_d[0] = $signed(X);
      for (int unsigned k = 1; k < NUM_TAPS; k++) taps_d[k] = taps_q[k-1];
    end
  end

  // Swap reads the pre-write shadow, so a same-cycle write lands in shadow only.
  always_comb begin
    shadow_d = shadow_q;
    active_d = active_q;
    if (COEF_SWAP) active_d = shadow_q;
    if (COEF_WE && (32'(COEF_ADDR) < NUM_TAPS)) shadow_d[COEF_ADDR] = $signed(COEF_DATA);
  end

  always_comb begin
    for (int unsigned k = 0; k < NUM_TAPS; k++) begin
      prod_d[k] = PW'(taps_q[k]) * PW'(active_q[k]);
    end
    vld2_d = vld1_q & ~FLUSH;
  end

  always_comb begin
    prod_flat = '0;
    for (int unsigned k = 0; k < NUM_TAPS; k++) prod_flat[k*PW +: PW] = prod_q[k];
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int unsigned k = 0; k < NUM_TAPS; k++) begin
        taps_q[k]   <= '0;
        shadow_q[k] <= '0;
        active_q[k] <= '0;
        prod_q[k]   <= '0;
      end
      vld1_q <= 1'b0;
      vld2_q <= 1'b0;
    end else begin
      taps_q   <= taps_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      prod_q   <= prod_d;
      vld1_q   <= vld1_d;
      vld2_q   <= vld2_d;
    end
  end

  fir_adder_tree #(
    .N (NUM_TAPS),
    .W (PW)
  ) u_tree (
    .clk_i   (CLK),
    .rst_ni  (RST_N),
    .clr_i   (FLUSH),
    .valid_i (vld2_q),
    .data_i  (prod_flat),
    .sum_o   (tree_sum),
    .valid_o (tree_vld)
  );

  // One spare bit absorbs the rounding bias without wrapping.
  always_comb begin
    biased = RW'($signed(tree_sum)) + RndBias;
    rnd_d  = biased >>> SHIFT;
    vld3_d = tree_vld & ~FLUSH;
  end

  if (OUT_WIDTH >= RW) begin : g_nosat
    assign clip     = OUT_WIDTH'(rnd_q);
    assign clip_hit = 1'b0;
  end else begin : g_sat
    localparam logic signed [RW-1:0] YMax = {{(RW-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
    localparam logic signed [RW-1:0] YMin = {{(RW-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
    always_comb begin
      clip     = rnd_q[OUT_WIDTH-1:0];
      clip_hit = 1'b0;
      if (rnd_q > YMax) begin
        clip     = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        clip_hit = 1'b1;
      end else if (rnd_q < YMin) begin
        clip     = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        clip_hit = 1'b1;
      end
    end
  end

  always_comb begin
    y_strb_d = vld3_q & ~FLUSH;
    y_d      = y_q;
    y_sat_d  = y_sat_q;
    if (y_strb_d) begin
      y_d     = clip;
      y_sat_d = clip_hit;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rnd_q    <= '0;
      vld3_q   <= 1'b0;
      y_q      <= '0;
      y_strb_q <= 1'b0;
      y_sat_q  <= 1'b0;
    end else begin
      rnd_q    <= rnd_d;
      vld3_q   <= vld3_d;
      y_q      <= y_d;
      y_strb_q <= y_strb_d;
      y_sat_q  <= y_sat_d;
    end
  end

  assign Y      = y_q;
  assign Y_STRB = y_strb_q;
  assign Y_SAT  = y_sat_q;

endmodule

// File: tb/tb_fir_1d_n_logic.sv
// Two FIR instances (SHIFT=0/OUT=20 and SHIFT=8/OUT=48) on shared stimulus,
// checked every cycle against a sample-indexed convolution model plus literal cases.
module tb_fir_1d_n_logic;

  localparam int NT = 5;
  localparam int L  = 6;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [17:0] x;
  logic        x_strb, flush, coef_we, coef_swap;
  logic [2:0]  coef_addr;
  logic [17:0] coef_data;
  logic [19:0] y0;
  logic        ys0, yt0;
  logic [47:0] y1;
  logic        ys1, yt1;

  always #5 clk = ~clk;

  fir_1d_n_logic #(
    .NUM_TAPS(NT), .IN_WIDTH(18), .COEF_WIDTH(18), .OUT_WIDTH(20), .SHIFT(0)
  ) u_dut0 (
    .CLK(clk), .RST_N(rst_n), .X(x), .X_STRB(x_strb), .FLUSH(flush), .COEF_WE(coef_we),
    .COEF_ADDR(coef_addr), .COEF_DATA(coef_data), .COEF_SWAP(coef_swap),
    .Y(y0), .Y_STRB(ys0), .Y_SAT(yt0)
  );

  fir_1d_n_logic #(
    .NUM_TAPS(NT), .IN_WIDTH(18), .COEF_WIDTH(18), .OUT_WIDTH(48), .SHIFT(8)
  ) u_dut1 (
    .CLK(clk), .RST_N(rst_n), .X(x), .X_STRB(x_strb), .FLUSH(flush), .COEF_WE(coef_we),
    .COEF_ADDR(coef_addr), .COEF_DATA(coef_data), .COEF_SWAP(coef_swap),
    .Y(y1), .Y_STRB(ys1), .Y_SAT(yt1)
  );

  typedef struct { int due; longint sum; } pend_t;
  typedef struct { int cyc; longint y; bit sat; } cap_t;

  int     cyc = 0;
  int     n_cmp = 0;
  int     n_bad = 0;
  longint hist [NT];
  longint shadow [NT];
  longint active [NT];
  pend_t  pend [$];
  cap_t   got0 [$];
  cap_t   got1 [$];
  longint last_y0, last_y1;
  bit     last_s0, last_s1;

  function automatic void out_rule(input longint s, input int sh, input int ow,
                                   output longint y, output bit sat);
    longint mx, mn;
    if (sh > 0) s = s + (longint'(1) << (sh - 1));
    s   = s >>> sh;
    mx  = (longint'(1) << (ow - 1)) - 1;
    mn  = -(longint'(1) << (ow - 1));
    y   = s;
    sat = 1'b0;
    if (s > mx) begin y = mx; sat = 1'b1; end
    else if (s < mn) begin y = mn; sat = 1'b1; end
  endfunction

  function automatic void model_clear();
    for (int k = 0; k < NT; k++) begin hist[k] = 0; shadow[k] = 0; active[k] = 0; end
    pend.delete();
    last_y0 = 0; last_y1 = 0; last_s0 = 0; last_s1 = 0;
  endfunction

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
    end
  endtask

  // Model: one convolution per accepted sample, due L edges later.
  initial forever begin
    @(posedge clk);
    cyc++;
    if (!rst_n) begin
      model_clear();
    end else begin
      if (coef_swap) active = shadow;
      if (coef_we && coef_addr < NT) shadow[coef_addr] = longint'($signed(coef_data));
      if (flush) begin
        for (int k = 0; k < NT; k++) hist[k] = 0;
        while (pend.size() > 0 && pend[$].due >= cyc) void'(pend.pop_back());
      end else if (x_strb) begin
        longint s;
        for (int k = NT - 1; k > 0; k--) hist[k] = hist[k-1];
        hist[0] = longint'($signed(x));
        s = 0;
        for (int k = 0; k < NT; k++) s += active[k] * hist[k];
        pend.push_back('{due: cyc + L, sum: s});
      end
    end
  end

  // Compare every cycle: strobe, value (held when idle) and saturation flag.
  initial forever begin
    bit     on;
    longint ey0, ey1;
    bit     es0, es1;
    @(negedge clk);
    if (!rst_n) begin
      model_clear();
      check("rst_y0", longint'($signed(y0)), 0);
      check("rst_strb0", ys0, 0);
      check("rst_sat0", yt0, 0);
      check("rst_y1", longint'($signed(y1)), 0);
      check("rst_strb1", ys1, 0);
      check("rst_sat1", yt1, 0);
    end else begin
      on = pend.size() > 0 && pend[0].due == cyc;
      if (on) begin
        out_rule(pend[0].sum, 0, 20, ey0, es0);
        out_rule(pend[0].sum, 8, 48, ey1, es1);
        void'(pend.pop_front());
        last_y0 = ey0; last_s0 = es0; last_y1 = ey1; last_s1 = es1;
      end else begin
        ey0 = last_y0; es0 = last_s0; ey1 = last_y1; es1 = last_s1;
      end
      check("y_strb0", ys0, on);
      check("y0", longint'($signed(y0)), ey0);
      check("y_sat0", yt0, es0);
      check("y_strb1", ys1, on);
      check("y1", longint'($signed(y1)), ey1);
      check("y_sat1", yt1, es1);
      if (ys0) got0.push_back('{cyc: cyc, y: longint'($signed(y0)), sat: yt0});
      if (ys1) got1.push_back('{cyc: cyc, y: longint'($signed(y1)), sat: yt1});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    x_strb = 0; flush = 0; coef_we = 0; coef_swap = 0; x = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic sample(input int v);
    x = 18'(v);
    x_strb = 1;
    tick();
  endtask

  task automatic load(input int c0, input int c1, input int c2, input int c3, input int c4);
    int c [NT];
    c = '{c0, c1, c2, c3, c4};
    for (int k = 0; k < NT; k++) begin
      coef_we = 1; coef_addr = 3'(k); coef_data = 18'(c[k]);
      tick();
    end
    coef_swap = 1;
    tick();
  endtask

  task automatic impulse_check(input string tag);
    int e0;
    got0.delete(); got1.delete();
    e0 = cyc + 1;
    sample(1);
    repeat (4) sample(0);
    idle(12);
    check({tag, "_count"}, got0.size(), 5);
    for (int i = 0; i < got0.size() && i < 5; i++) begin
      check({tag, "_y"}, got0[i].y, i + 1);
      check({tag, "_lat"}, got0[i].cyc - e0, L + i);
    end
  endtask

  initial begin
    int e [5];
    int exp_r [3];
    rst_n = 0; x = '0; x_strb = 0; flush = 0; coef_we = 0; coef_swap = 0;
    coef_addr = '0; coef_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_y", longint'($signed(y0)), 0);
    check("reset_strb", ys0, 0);
    check("reset_sat", yt0, 0);
    @(posedge clk);
    #1 rst_n = 1;
    idle(2);

    load(1, 2, 3, 4, 5);
    impulse_check("impulse");

    got0.delete();
    for (int i = 0; i < 5; i++) begin
      e[i] = cyc + 1;
      sample(i == 0 ? 1 : 0);
      idle(2);
    end
    idle(10);
    check("gap_count", got0.size(), 5);
    for (int i = 0; i < got0.size() && i < 5; i++) begin
      check("gap_y", got0[i].y, i + 1);
      check("gap_lat", got0[i].cyc - e[i], L);
    end

    load(131071, 131071, 131071, 131071, 131071);
    got0.delete();
    repeat (5) sample(131071);
    idle(10);
    check("sat_count", got0.size(), 5);
    for (int i = 4; i < got0.size() && i < 5; i++) begin
      check("sat_y", got0[i].y, 524287);
      check("sat_flag", got0[i].sat, 1);
    end

    load(1, 0, 0, 0, 0);
    got1.delete();
    sample(384); sample(383); sample(-384);
    idle(10);
    exp_r = '{2, 1, -1};
    check("rnd_count", got1.size(), 3);
    for (int i = 0; i < got1.size() && i < 3; i++) check("rnd_y", got1[i].y, exp_r[i]);

    coef_we = 1; coef_addr = 0; coef_data = 18'd7;
    tick();
    coef_we = 1; coef_addr = 0; coef_data = 18'd9; coef_swap = 1;
    tick();
    got0.delete();
    sample(1);
    idle(10);
    check("collide_count", got0.size(), 1);
    for (int i = 0; i < got0.size() && i < 1; i++) check("collide_active", got0[i].y, 7);
    coef_swap = 1;
    tick();
    got0.delete();
    sample(1);
    idle(10);
    check("collide_count2", got0.size(), 1);
    for (int i = 0; i < got0.size() && i < 1; i++) check("collide_shadow", got0[i].y, 9);

    load(1, 2, 3, 4, 5);
    got0.delete();
    sample(3); sample(3); sample(3);
    flush = 1; x = 18'd5; x_strb = 1;
    tick();
    idle(12);
    check("flush_drop", got0.size(), 0);
    impulse_check("flush");

    got0.delete();
    sample(7); sample(-2); sample(4);
    #2 rst_n = 0;
    @(negedge clk);
    check("midrst_y", longint'($signed(y0)), 0);
    idle(2);
    rst_n = 1;
    idle(12);
    check("midrst_drop", got0.size(), 0);
    load(1, 2, 3, 4, 5);
    impulse_check("reset");

    for (int i = 0; i < 600; i++) begin
      x_strb    = ($urandom % 10) < 7;
      x         = ($urandom % 2) ? 18'($urandom) : 18'($urandom_range(0, 16) - 8);
      flush     = ($urandom % 40) == 0;
      coef_we   = ($urandom % 5) == 0;
      coef_addr = 3'($urandom % 8);
      coef_data = ($urandom % 2) ? 18'($urandom) : 18'($urandom_range(0, 16) - 8);
      coef_swap = ($urandom % 20) == 0;
      tick();
    end
    idle(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
